// File: rtl/request_control.sv
// Request-capture stage for the 4-floor car. Synchronises and edge-detects the
// call buttons, holds pending requests, and derives the up/down demand flags.
module request_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       switch,
    input  logic [3:0] car_btn,
    input  logic [3:0] hall_up,
    input  logic [3:0] hall_dn,
    input  logic [3:0] position,
    input  logic       opendoor,
    output logic [3:0] car_req,
    output logic [3:0] up_req,
    output logic [3:0] dn_req,
    output logic [3:0] allReq_reg,
    output logic       up_need,
    output logic       down_need
);

    // Button bit map: [3:0] car, [6:4] hall up floors 1..3, [9:7] hall down floors 2..4
    logic [9:0] btn_raw;
    logic [9:0] s1_q, s2_q, s3_q;
    logic [9:0] set_pulse;
    logic [1:0] warm_q, warm_d;
    logic       arm;
    logic       ignored_unused;

    logic [3:0] car_q, car_d;
    logic [2:0] up_q, up_d;
    logic [3:1] dn_q, dn_d;

    logic       pos_onehot;
    logic [3:0] clr;
    logic [3:0] above, below;

    assign btn_raw        = {hall_dn[3:1], hall_up[2:0], car_btn};
    assign ignored_unused = hall_up[3] ^ hall_dn[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // The history flop only holds a genuine sample from the third edge after
    // reset release; until then a held button would look like a fresh press.
    assign warm_d = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    assign arm    = (warm_q == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_q <= 2'd0;
        end else begin
            warm_q <= warm_d;
        end
    end

    assign set_pulse  = arm ? (s2_q & ~s3_q) : '0;
    assign pos_onehot = (position != 4'd0) && ((position & (position - 4'd1)) == 4'd0);
    assign clr        = (opendoor && pos_onehot) ? position : 4'd0;

    always_comb begin
        car_d = '0;
        up_d  = '0;
        dn_d  = '0;
        if (switch) begin
            car_d = (car_q | set_pulse[3:0]) & ~clr;
            up_d  = (up_q  | set_pulse[6:4]) & ~clr[2:0];
            dn_d  = (dn_q  | set_pulse[9:7]) & ~clr[3:1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            car_q <= '0;
            up_q  <= '0;
            dn_q  <= '0;
        end else begin
            car_q <= car_d;
            up_q  <= up_d;
            dn_q  <= dn_d;
        end
    end

    assign car_req    = car_q;
    assign up_req     = {1'b0, up_q};
    assign dn_req     = {dn_q, 1'b0};
    assign allReq_reg = car_req | up_req | dn_req;

    // above[i]: the car is below floor i; below[i]: the car is above floor i
    assign above = {|position[2:0], |position[1:0], position[0], 1'b0};
    assign below = {1'b0, position[3], |position[3:2], |position[3:1]};

    assign up_need   = pos_onehot && |(allReq_reg & above);
    assign down_need = pos_onehot && |(allReq_reg & below);

endmodule

// File: tb/tb_request_control.sv
// Bench for request_control: directed sequences, a position/demand vector table,
// and randomized traffic against a reference model built from per-edge samples.
module tb_request_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       switch;
    logic [3:0] car_btn, hall_up, hall_dn, position;
    logic       opendoor;
    logic [3:0] car_req, up_req, dn_req, allReq_reg;
    logic       up_need, down_need;

    int total  = 0;
    int passed = 0;

    request_control dut (
        .clk(clk), .rst_n(rst_n), .switch(switch),
        .car_btn(car_btn), .hall_up(hall_up), .hall_dn(hall_dn),
        .position(position), .opendoor(opendoor),
        .car_req(car_req), .up_req(up_req), .dn_req(dn_req),
        .allReq_reg(allReq_reg), .up_need(up_need), .down_need(down_need)
    );

    always #5 clk = ~clk;

    // Reference model: raw button samples per edge since reset; a press is a
    // sample seen high two edges ago that was low the edge before.
    logic [11:0] samples[$];
    logic [3:0]  m_car, m_up, m_dn;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samples.delete();
            m_car = 4'd0;
            m_up  = 4'd0;
            m_dn  = 4'd0;
        end else begin
            logic [11:0] pressed;
            logic [3:0]  clear;
            int n;
            samples.push_back({hall_dn, hall_up, car_btn});
            n = samples.size();
            pressed = 12'd0;
            if (n >= 4) pressed = samples[n-3] & ~samples[n-4];
            clear = (opendoor && $countones(position) == 1) ? position : 4'd0;
            if (!switch) begin
                m_car = 4'd0;
                m_up  = 4'd0;
                m_dn  = 4'd0;
            end else begin
                m_car = (m_car | pressed[3:0])  & ~clear;
                m_up  = (m_up  | pressed[7:4])  & ~clear & 4'b0111;
                m_dn  = (m_dn  | pressed[11:8]) & ~clear & 4'b1110;
            end
        end
    end

    // {up, down}: pending floors strictly above / below the single current floor
    function automatic logic [1:0] need_of(logic [3:0] req, logic [3:0] pos);
        int f;
        logic u, d;
        if ($countones(pos) != 1) return 2'b00;
        f = 0;
        for (int i = 0; i < 4; i++) if (pos[i]) f = i;
        u = 1'b0;
        d = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (req[j] && j > f) u = 1'b1;
            if (req[j] && j < f) d = 1'b1;
        end
        return {u, d};
    endfunction

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
    endtask

    task automatic check_model();
        logic [1:0] nd;
        nd = need_of(m_car | m_up | m_dn, position);
        chk("model car_req", car_req, m_car);
        chk("model up_req", up_req, m_up);
        chk("model dn_req", dn_req, m_dn);
        chk("model allReq", allReq_reg, m_car | m_up | m_dn);
        chk("model needs", {2'b00, up_need, down_need}, {2'b00, nd});
    endtask

    task automatic tick(int cnt = 1);
        for (int i = 0; i < cnt; i++) begin
            @(posedge clk);
            #2;
            check_model();
        end
    endtask

    typedef struct {
        logic [3:0] pos;
        logic       exp_up;
        logic       exp_dn;
    } need_vec_t;

    need_vec_t vecs[7];

    initial begin
        // requests pending at floors 1 and 4
        vecs[0] = '{4'b0001, 1'b1, 1'b0};
        vecs[1] = '{4'b0010, 1'b1, 1'b1};
        vecs[2] = '{4'b0100, 1'b1, 1'b1};
        vecs[3] = '{4'b1000, 1'b0, 1'b1};
        vecs[4] = '{4'b0000, 1'b0, 1'b0};
        vecs[5] = '{4'b0011, 1'b0, 1'b0};
        vecs[6] = '{4'b1111, 1'b0, 1'b0};

        // Reset with every button held, then release still held
        rst_n = 1'b0; switch = 1'b1; opendoor = 1'b0; position = 4'b0001;
        car_btn = 4'hF; hall_up = 4'hF; hall_dn = 4'hF;
        #1;
        chk("reset allReq", allReq_reg, 4'd0);
        chk("reset needs", {2'b00, up_need, down_need}, 4'd0);
        repeat (3) @(posedge clk);
        #2;
        chk("reset car_req held", car_req, 4'd0);
        rst_n = 1'b1;
        tick(6);
        chk("held through reset", allReq_reg, 4'd0);
        car_btn = 4'd0; hall_up = 4'd0; hall_dn = 4'd0;
        tick(4);

        // Press latency
        car_btn[2] = 1'b1;
        tick(1); chk("latency edge k", car_req, 4'd0);
        tick(1); chk("latency edge k+1", car_req, 4'd0);
        tick(1); chk("latency edge k+2", car_req, 4'b0100);
        chk("latency allReq", allReq_reg, 4'b0100);
        chk("latency needs", {2'b00, up_need, down_need}, 4'b0010);
        car_btn[2] = 1'b0;
        tick(2);

        // Clear beats set at the open floor
        position = 4'b0100; opendoor = 1'b1;
        hall_up[2] = 1'b1; car_btn[0] = 1'b1;
        tick(4);
        chk("clear prio up_req", up_req, 4'd0);
        chk("clear prio car_req", car_req, 4'b0001);
        chk("clear prio needs", {2'b00, up_need, down_need}, 4'b0001);
        hall_up[2] = 1'b0; car_btn[0] = 1'b0; opendoor = 1'b0;
        tick(3);

        // Held button does not re-assert after clearing
        position = 4'b0001;
        hall_up[1] = 1'b1;
        tick(3); chk("held set", up_req, 4'b0010);
        position = 4'b0010; opendoor = 1'b1;
        tick(1); chk("held cleared", up_req, 4'd0);
        opendoor = 1'b0;
        tick(5); chk("held stays clear", up_req, 4'd0);
        hall_up[1] = 1'b0;
        tick(3);
        hall_up[1] = 1'b1;
        tick(2); chk("repress early", up_req, 4'd0);
        tick(1); chk("repress set", up_req, 4'b0010);
        hall_up[1] = 1'b0;

        // Master switch flush
        car_btn[3] = 1'b1;
        tick(3); car_btn[3] = 1'b0;
        chk("switch pre", allReq_reg, 4'b1011);
        switch = 1'b0;
        tick(1); chk("switch flush", allReq_reg, 4'd0);
        car_btn[2] = 1'b1;
        tick(4); chk("switch off press", allReq_reg, 4'd0);
        switch = 1'b1;
        tick(5); chk("switch on held", allReq_reg, 4'd0);
        car_btn[2] = 1'b0;
        tick(3);

        // Ignored bits and invalid position
        hall_up[3] = 1'b1; hall_dn[0] = 1'b1;
        tick(4);
        chk("ignored up_req", up_req, 4'd0);
        chk("ignored dn_req", dn_req, 4'd0);
        hall_up[3] = 1'b0; hall_dn[0] = 1'b0;
        car_btn = 4'b1001;
        tick(3); car_btn = 4'd0;
        chk("pending 1001", allReq_reg, 4'b1001);
        position = 4'b0000;
        #1;
        chk("invalid pos needs", {2'b00, up_need, down_need}, 4'd0);
        opendoor = 1'b1;
        tick(2); chk("invalid pos no clear", allReq_reg, 4'b1001);
        opendoor = 1'b0;
        tick(1);

        // Demand table against fixed requests
        for (int i = 0; i < 7; i++) begin
            position = vecs[i].pos;
            #1;
            chk($sformatf("need table %b", vecs[i].pos),
                {2'b00, up_need, down_need}, {2'b00, vecs[i].exp_up, vecs[i].exp_dn});
            tick(1);
            chk("need table retain", allReq_reg, 4'b1001);
        end

        // Reset mid-operation is immediate
        rst_n = 1'b0;
        #1;
        chk("mid reset", allReq_reg, 4'd0);
        tick(2);
        rst_n = 1'b1;
        position = 4'b0001;
        tick(4);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(7) == 0) car_btn[b] = ~car_btn[b];
                if ($urandom_range(7) == 0) hall_up[b] = ~hall_up[b];
                if ($urandom_range(7) == 0) hall_dn[b] = ~hall_dn[b];
            end
            if ($urandom_range(3) == 0) begin
                if ($urandom_range(9) == 0) position = 4'($urandom_range(15));
                else position = 4'b0001 << $urandom_range(3);
            end
            opendoor = ($urandom_range(5) == 0);
            if (switch && $urandom_range(39) == 0) switch = 1'b0;
            else if (!switch && $urandom_range(4) == 0) switch = 1'b1;
            rst_n = ($urandom_range(299) != 0);
            tick(1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
